// File: rtl/pixel_clock_gen.sv
// Programmable clock-enable generator: divides clk by a runtime divisor and emits
// a one-cycle tick plus a registered near-50% dclk, with period-boundary divisor swaps.
module pixel_clock_gen #(
    parameter int CNT_W     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_wr,
    input  logic             err_clr,
    output logic             tick,
    output logic             dclk,
    output logic [CNT_W-1:0] phase,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] div_pend;
    logic             pend_v;

    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] div_nx;
    logic [CNT_W-1:0] pend_nx;
    logic             pend_v_nx;
    logic             tick_nx;
    logic             dclk_nx;
    logic             err_nx;
    logic             wrap;
    logic             wr_ok;
    logic             wr_bad;

    function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] d);
        return (d >> 1) + {{(CNT_W-1){1'b0}}, d[0]};
    endfunction

    // A divide-by-one output has no low/high split, so dclk is parked low.
    function automatic logic dclk_level(input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] d);
        return (d != ONE) && (c < half_up(d));
    endfunction

    always_comb begin
        wrap      = run && (cnt == div_cur - ONE);
        wr_ok     = div_wr && (div_in != '0);
        wr_bad    = div_wr && (div_in == '0);
        cnt_nx    = cnt;
        div_nx    = div_cur;
        pend_nx   = div_pend;
        pend_v_nx = pend_v;
        tick_nx   = 1'b0;

        // Period boundary (wrap) or realign (sync, which suppresses the tick).
        if (sync || wrap) begin
            cnt_nx  = '0;
            tick_nx = ~sync;
            if (pend_v) begin
                div_nx    = div_pend;
                pend_v_nx = 1'b0;
            end
        end else if (run) begin
            cnt_nx = cnt + ONE;
        end

        // A write lands after the boundary swap, so it either queues behind it
        // or, while frozen, replaces the divisor outright.
        if (wr_ok) begin
            if (run) begin
                pend_nx   = div_in;
                pend_v_nx = 1'b1;
            end else begin
                div_nx    = div_in;
                cnt_nx    = '0;
                pend_v_nx = 1'b0;
            end
        end

        if (wr_bad) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end else begin
            err_nx = err;
        end

        dclk_nx = dclk_level(cnt_nx, div_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_cur <= DIV_RST;
            pend_v  <= 1'b0;
            tick    <= 1'b0;
            dclk    <= 1'b0;
            err     <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            div_cur <= div_nx;
            pend_v  <= pend_v_nx;
            tick    <= tick_nx;
            dclk    <= dclk_nx;
            err     <= err_nx;
        end
    end

    // The pending value is only ever read while pend_v is set.
    always_ff @(posedge clk) begin
        div_pend <= pend_nx;
    end

    assign phase = cnt;
    assign busy  = pend_v;

endmodule
